// File: rtl/hyperbus_pkg.sv
// Shared HyperBus definitions: responder FSM encodings, command/address bit positions
// and wrapped-burst geometry.
package hyperbus_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CA     = 3'd1;
    localparam logic [2:0] ST_LAT    = 3'd2;
    localparam logic [2:0] ST_RD     = 3'd3;
    localparam logic [2:0] ST_WR     = 3'd4;
    localparam logic [2:0] ST_REG_WR = 3'd5;

    localparam int CA_RW = 47;
    localparam int CA_AS = 46;
    localparam int CA_BT = 45;

    localparam int WRAP_WORDS = 16;
    localparam int WRAP_BITS  = $clog2(WRAP_WORDS);

    // Next word offset inside an aligned wrap group; rolls over at the group end.
    function automatic logic [WRAP_BITS-1:0] wrap_inc(input logic [WRAP_BITS-1:0] offset);
        return offset + {{(WRAP_BITS-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/hyperram_word_array.sv
// Single-port 16-bit word store with per-byte write enables and a registered read port.
module hyperram_word_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [1:0]        be,
    input  logic [15:0]       wdata,
    input  logic              re,
    output logic [15:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [15:0] mem_r [DEPTH];

    // Byte-masked write; contents deliberately carry no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            if (be[1]) begin
                mem_r[addr][15:8] <= wdata[15:8];
            end
            if (be[0]) begin
                mem_r[addr][7:0] <= wdata[7:0];
            end
        end
    end

    // Registered read data, only refreshed when a read is requested.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rdata <= 16'h0000;
        end else if (re) begin
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/hyperram_responder.sv
// HyperBus device-side responder: decodes the 48-bit CA, applies initial latency and
// serves linear or wrapped bursts from the word array; register space returns ID0.
module hyperram_responder
    import hyperbus_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter int          LATENCY  = 6,
    parameter bit          FIXED_2X = 1'b1,
    parameter logic [15:0] ID0      = 16'h0C81
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       hyperram_ck_en,
    input  logic       hyperram_ce_from_pad_,
    input  logic [7:0] hyperram_dq_from_pad_0,
    input  logic [7:0] hyperram_dq_from_pad_1,
    input  logic       hyperram_rwds_from_pad_0,
    input  logic       hyperram_rwds_from_pad_1,
    output logic [7:0] hyperram_dq_to_pad_0,
    output logic [7:0] hyperram_dq_to_pad_1,
    output logic       hyperram_rwds_to_pad_0,
    output logic       hyperram_rwds_to_pad_1,
    output logic       hyperram_dq_dir,
    output logic       hyperram_rwds_dir
);

    localparam int         LAT_TOTAL = FIXED_2X ? 2 * LATENCY : LATENCY;
    localparam logic [7:0] LAT_INIT  = 8'(LAT_TOTAL - 1);

    logic [2:0]        state_r;
    logic [1:0]        beat_cnt_r;
    logic [5:0]        ca_w0_r;
    logic [15:0]       ca_w1_r;
    logic              rw_r;
    logic              as_r;
    logic              bt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        lat_cnt_r;
    logic [15:0]       cr0_r;
    logic              cr0_done_r;

    logic              beat_s;
    logic [15:0]       word_in_s;
    logic [21:0]       ca_addr_full_s;
    logic [ADDR_W-1:0] addr_next_s;
    logic              rd_en_s;
    logic              wr_en_s;
    logic [15:0]       rd_data_s;
    logic              unused_s;

    assign beat_s         = !hyperram_ce_from_pad_ && hyperram_ck_en;
    assign word_in_s      = {hyperram_dq_from_pad_0, hyperram_dq_from_pad_1};
    // Word address = {CA[34:16], CA[2:0]}; the third CA word supplies the low bits.
    assign ca_addr_full_s = {ca_w0_r[2:0], ca_w1_r, word_in_s[2:0]};
    assign unused_s       = ^{ca_addr_full_s, cr0_r};

    // The array read for word N is issued one beat ahead of driving it onto the pads.
    assign rd_en_s = beat_s && ((state_r == ST_RD) ||
                                ((state_r == ST_LAT) && (lat_cnt_r == 8'd0) && rw_r));
    assign wr_en_s = beat_s && (state_r == ST_WR);

    // Burst address advance: linear over the whole array, or wrap within the 16-word group.
    always_comb begin
        addr_next_s = addr_r;
        if (bt_r) begin
            addr_next_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            addr_next_s = {addr_r[ADDR_W-1:WRAP_BITS], wrap_inc(addr_r[WRAP_BITS-1:0])};
        end
    end

    hyperram_word_array #(
        .ADDR_W (ADDR_W)
    ) u_word_array (
        .clk    (clk),
        .reset_ (reset_),
        .addr   (addr_r),
        .we     (wr_en_s),
        .be     ({!hyperram_rwds_from_pad_0, !hyperram_rwds_from_pad_1}),
        .wdata  (word_in_s),
        .re     (rd_en_s),
        .rdata  (rd_data_s)
    );

    // Transaction FSM, CA capture, latency/address counters and registered pad outputs.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_r                <= ST_IDLE;
            beat_cnt_r             <= 2'd0;
            ca_w0_r                <= 6'd0;
            ca_w1_r                <= 16'h0000;
            rw_r                   <= 1'b0;
            as_r                   <= 1'b0;
            bt_r                   <= 1'b0;
            addr_r                 <= '0;
            lat_cnt_r              <= 8'd0;
            cr0_r                  <= 16'h0000;
            cr0_done_r             <= 1'b0;
            hyperram_dq_to_pad_0   <= 8'h00;
            hyperram_dq_to_pad_1   <= 8'h00;
            hyperram_rwds_to_pad_0 <= 1'b0;
            hyperram_rwds_to_pad_1 <= 1'b0;
            hyperram_dq_dir        <= 1'b0;
            hyperram_rwds_dir      <= 1'b0;
        end else if (hyperram_ce_from_pad_) begin
            // Deselect wins over any beat presented in the same cycle.
            state_r                <= ST_IDLE;
            beat_cnt_r             <= 2'd0;
            hyperram_dq_to_pad_0   <= 8'h00;
            hyperram_dq_to_pad_1   <= 8'h00;
            hyperram_rwds_to_pad_0 <= 1'b0;
            hyperram_rwds_to_pad_1 <= 1'b0;
            hyperram_dq_dir        <= 1'b0;
            hyperram_rwds_dir      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r                <= ST_CA;
                    beat_cnt_r             <= 2'd0;
                    hyperram_rwds_dir      <= 1'b1;
                    hyperram_rwds_to_pad_0 <= FIXED_2X;
                    hyperram_rwds_to_pad_1 <= FIXED_2X;
                end
                ST_CA: begin
                    if (hyperram_ck_en) begin
                        beat_cnt_r <= beat_cnt_r + 2'd1;
                        if (beat_cnt_r == 2'd0) begin
                            ca_w0_r <= {word_in_s[CA_RW-32], word_in_s[CA_AS-32],
                                        word_in_s[CA_BT-32], word_in_s[2:0]};
                        end else if (beat_cnt_r == 2'd1) begin
                            ca_w1_r <= word_in_s;
                        end else begin
                            rw_r                   <= ca_w0_r[5];
                            as_r                   <= ca_w0_r[4];
                            bt_r                   <= ca_w0_r[3];
                            addr_r                 <= ca_addr_full_s[ADDR_W-1:0];
                            lat_cnt_r              <= LAT_INIT;
                            cr0_done_r             <= 1'b0;
                            hyperram_rwds_dir      <= 1'b0;
                            hyperram_rwds_to_pad_0 <= 1'b0;
                            hyperram_rwds_to_pad_1 <= 1'b0;
                            state_r <= (ca_w0_r[4] && !ca_w0_r[5]) ? ST_REG_WR : ST_LAT;
                        end
                    end
                end
                ST_LAT: begin
                    if (hyperram_ck_en) begin
                        if (lat_cnt_r == 8'd0) begin
                            state_r <= rw_r ? ST_RD : ST_WR;
                            if (rw_r) begin
                                addr_r <= addr_next_s;
                            end
                        end else begin
                            lat_cnt_r <= lat_cnt_r - 8'd1;
                        end
                    end
                end
                ST_RD: begin
                    if (hyperram_ck_en) begin
                        {hyperram_dq_to_pad_0, hyperram_dq_to_pad_1} <= as_r ? ID0 : rd_data_s;
                        hyperram_rwds_to_pad_0 <= 1'b1;
                        hyperram_rwds_to_pad_1 <= 1'b0;
                        hyperram_dq_dir        <= 1'b1;
                        hyperram_rwds_dir      <= 1'b1;
                        addr_r                 <= addr_next_s;
                    end
                end
                ST_WR: begin
                    if (hyperram_ck_en) begin
                        addr_r <= addr_next_s;
                    end
                end
                ST_REG_WR: begin
                    if (hyperram_ck_en && !cr0_done_r) begin
                        cr0_r      <= word_in_s;
                        cr0_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyperram_responder.sv
// Randomized self-checking bench for hyperram_responder against a word-array reference model.
module tb_hyperram_responder;

    localparam int          ADDR_W   = 8;
    localparam int          DEPTH    = 1 << ADDR_W;
    localparam int          LATENCY  = 6;
    localparam bit          FIXED_2X = 1'b1;
    localparam logic [15:0] ID0      = 16'h0C81;
    localparam int          LAT_CYC  = FIXED_2X ? 2 * LATENCY : LATENCY;

    logic       clk = 1'b0;
    logic       reset_;
    logic       ck_en;
    logic       ce_;
    logic [7:0] dq_in_0;
    logic [7:0] dq_in_1;
    logic       rwds_in_0;
    logic       rwds_in_1;
    logic [7:0] dq_out_0;
    logic [7:0] dq_out_1;
    logic       rwds_out_0;
    logic       rwds_out_1;
    logic       dq_dir;
    logic       rwds_dir;

    int errors = 0;
    int checks = 0;

    logic [15:0] model_mem [DEPTH];
    logic [15:0] wbuf [DEPTH];
    logic [1:0]  mbuf [DEPTH];

    always #5 clk = ~clk;

    hyperram_responder #(
        .ADDR_W   (ADDR_W),
        .LATENCY  (LATENCY),
        .FIXED_2X (FIXED_2X),
        .ID0      (ID0)
    ) dut (
        .clk                      (clk),
        .reset_                   (reset_),
        .hyperram_ck_en           (ck_en),
        .hyperram_ce_from_pad_    (ce_),
        .hyperram_dq_from_pad_0   (dq_in_0),
        .hyperram_dq_from_pad_1   (dq_in_1),
        .hyperram_rwds_from_pad_0 (rwds_in_0),
        .hyperram_rwds_from_pad_1 (rwds_in_1),
        .hyperram_dq_to_pad_0     (dq_out_0),
        .hyperram_dq_to_pad_1     (dq_out_1),
        .hyperram_rwds_to_pad_0   (rwds_out_0),
        .hyperram_rwds_to_pad_1   (rwds_out_1),
        .hyperram_dq_dir          (dq_dir),
        .hyperram_rwds_dir        (rwds_dir)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_addr(input int a, input bit linear);
        if (linear) return (a + 1) % DEPTH;
        return (a / 16) * 16 + ((a % 16) + 1) % 16;
    endfunction

    // Present one cycle of bus inputs, then sample just after the clock edge.
    task automatic bus_cycle(input logic ce, input logic en, input logic [15:0] w, input logic [1:0] m);
        ce_       = ce;
        ck_en     = en;
        dq_in_0   = w[15:8];
        dq_in_1   = w[7:0];
        rwds_in_0 = m[1];
        rwds_in_1 = m[0];
        @(posedge clk);
        #1;
    endtask

    task automatic start_txn(input bit rw, input bit as, input bit linear, input int addr);
        logic [47:0] ca;
        ca        = {16'($urandom), 16'($urandom), 16'($urandom)};
        ca[47]    = rw;
        ca[46]    = as;
        ca[45]    = linear;
        ca[34:16] = 19'(($urandom << (ADDR_W - 3)) | (addr >> 3));
        ca[2:0]   = 3'(addr & 7);
        bus_cycle(1'b0, 1'b0, 16'h0000, 2'b00);
        check_eq("ca_rwds_dir", 32'(rwds_dir), 32'd1);
        check_eq("ca_latency_flag", 32'({rwds_out_0, rwds_out_1}), 32'({FIXED_2X, FIXED_2X}));
        bus_cycle(1'b0, 1'b1, ca[47:32], 2'b00);
        bus_cycle(1'b0, 1'b1, ca[31:16], 2'b00);
        bus_cycle(1'b0, 1'b1, ca[15:0], 2'b00);
        check_eq("ca_done_rwds_dir", 32'(rwds_dir), 32'd0);
    endtask

    task automatic run_latency();
        int n = 0;
        while (n < LAT_CYC) begin
            if ($urandom_range(0, 3) == 0) begin
                bus_cycle(1'b0, 1'b0, 16'($urandom), 2'b00);
            end else begin
                bus_cycle(1'b0, 1'b1, 16'($urandom), 2'b00);
                n++;
            end
        end
    endtask

    // Deselect with a beat offered in the same cycle; the beat must be ignored.
    task automatic end_txn();
        bus_cycle(1'b1, 1'b1, 16'($urandom), 2'b00);
        check_eq("ce_release_dirs", 32'({dq_dir, rwds_dir}), 32'd0);
    endtask

    task automatic do_read(input bit as, input bit linear, input int addr, input int n);
        int a = addr;
        logic [15:0] exp_w;
        start_txn(1'b1, as, linear, addr);
        run_latency();
        check_eq("rd_no_early_drive", 32'(dq_dir), 32'd0);
        for (int k = 0; k < n; k++) begin
            bus_cycle(1'b0, 1'b1, 16'h0000, 2'b00);
            exp_w = as ? ID0 : model_mem[a];
            check_eq("rd_data", 32'({dq_out_0, dq_out_1}), 32'(exp_w));
            check_eq("rd_strobe_dirs", 32'({dq_dir, rwds_dir, rwds_out_0, rwds_out_1}), 32'b1110);
            a = next_addr(a, linear);
            if ($urandom_range(0, 4) == 0) begin
                bus_cycle(1'b0, 1'b0, 16'h0000, 2'b00);
                check_eq("rd_hold", 32'({dq_dir, dq_out_0, dq_out_1}), 32'({1'b1, exp_w}));
            end
        end
        end_txn();
    endtask

    task automatic do_write(input bit linear, input int addr, input int n);
        int a = addr;
        start_txn(1'b0, 1'b0, linear, addr);
        run_latency();
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                bus_cycle(1'b0, 1'b0, 16'($urandom), 2'b00);
            end
            bus_cycle(1'b0, 1'b1, wbuf[k], mbuf[k]);
            if (!mbuf[k][1]) model_mem[a][15:8] = wbuf[k][15:8];
            if (!mbuf[k][0]) model_mem[a][7:0]  = wbuf[k][7:0];
            a = next_addr(a, linear);
        end
        end_txn();
    endtask

    task automatic do_reg_write(input int addr, input logic [15:0] val);
        start_txn(1'b0, 1'b1, 1'b1, addr);
        bus_cycle(1'b0, 1'b0, 16'h0000, 2'b00);
        bus_cycle(1'b0, 1'b1, val, 2'b00);
        bus_cycle(1'b0, 1'b1, ~val, 2'b00);
        bus_cycle(1'b0, 1'b1, 16'h5555, 2'b00);
        check_eq("cr0_value", 32'(dut.cr0_r), 32'(val));
        check_eq("reg_wr_quiet", 32'({dq_dir, rwds_dir}), 32'd0);
        end_txn();
    endtask

    // Assert reset between clock edges; outputs must clear without waiting for an edge.
    task automatic reset_pulse(input string tag);
        #2;
        reset_ = 1'b0;
        #1;
        check_eq(tag, 32'({dq_out_0, dq_out_1, rwds_out_0, rwds_out_1, dq_dir, rwds_dir}), 32'd0);
        ce_   = 1'b1;
        ck_en = 1'b0;
        @(posedge clk);
        #1;
        reset_ = 1'b1;
    endtask

    initial begin
        reset_    = 1'b0;
        ce_       = 1'b1;
        ck_en     = 1'b0;
        dq_in_0   = 8'h00;
        dq_in_1   = 8'h00;
        rwds_in_0 = 1'b0;
        rwds_in_1 = 1'b0;
        #23;
        check_eq("reset_outputs",
                 32'({dq_out_0, dq_out_1, rwds_out_0, rwds_out_1, dq_dir, rwds_dir}), 32'd0);
        @(posedge clk);
        #1;
        reset_ = 1'b1;
        bus_cycle(1'b1, 1'b0, 16'h0000, 2'b00);

        // Fill the whole array so every later read has a known expectation.
        for (int i = 0; i < DEPTH; i++) begin
            wbuf[i] = 16'($urandom);
            mbuf[i] = 2'b00;
        end
        do_write(1'b1, 0, DEPTH);

        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
        for (int i = 0; i < 4; i++) mbuf[i] = 2'b00;
        do_write(1'b1, 'h010, 4);
        do_read(1'b0, 1'b1, 'h010, 4);

        wbuf[0] = 16'hABCD; mbuf[0] = 2'b00;
        do_write(1'b1, 'h020, 1);
        wbuf[0] = 16'h1234; mbuf[0] = 2'b10;
        do_write(1'b1, 'h020, 1);
        do_read(1'b0, 1'b1, 'h020, 1);

        do_read(1'b0, 1'b0, 'h01E, 4);
        do_read(1'b0, 1'b1, DEPTH - 1, 3);
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 16'($urandom);
            mbuf[i] = 2'b00;
        end
        do_write(1'b0, 'h02E, 4);
        do_read(1'b0, 1'b1, 'h020, 16);

        do_read(1'b0, 1'b1, 'h030, 2);
        do_read(1'b0, 1'b1, 'h030, 3);

        do_read(1'b1, 1'b1, 'h005, 5);
        do_reg_write('h010, 16'h8F1F);
        do_read(1'b0, 1'b1, 'h010, 4);

        start_txn(1'b1, 1'b0, 1'b1, 'h050);
        run_latency();
        bus_cycle(1'b0, 1'b1, 16'h0000, 2'b00);
        check_eq("pre_reset_rd_drive", 32'(dq_dir), 32'd1);
        reset_pulse("reset_mid_rd");

        start_txn(1'b0, 1'b0, 1'b1, 'h040);
        run_latency();
        bus_cycle(1'b0, 1'b1, 16'h5A5A, 2'b00);
        model_mem['h040] = 16'h5A5A;
        bus_cycle(1'b0, 1'b1, 16'hA5C3, 2'b00);
        model_mem['h041] = 16'hA5C3;
        reset_pulse("reset_mid_wr");
        do_read(1'b0, 1'b1, 'h03F, 4);

        for (int t = 0; t < 25; t++) begin
            int a;
            int n;
            a = $urandom_range(0, DEPTH - 1);
            n = $urandom_range(1, 24);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < n; i++) begin
                    wbuf[i] = 16'($urandom);
                    mbuf[i] = 2'($urandom);
                end
                do_write(1'($urandom), a, n);
            end else begin
                do_read(($urandom_range(0, 7) == 0), 1'($urandom), a, n);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
